// File: rtl/uart_rx_packet_ctrl_pkg.sv
// Shared types for the uart_rx packet sequencer.
//   SYNC_WORD_DEFAULT : packet start marker
//   state_t           : controller FSM states
//   err_t             : cause reported on err_code when a packet is dropped
package uart_rx_packet_ctrl_pkg;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

endpackage

// File: rtl/uart_rx_packet_ctrl_if.sv
// Downstream payload stream (valid/ready with end-of-packet flag).
//   data  : payload word at the FIFO head
//   last  : head word is the final payload word of its packet
//   valid : a committed word is available
//   ready : sink accepts; the word is consumed when valid && ready
interface uart_rx_packet_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             last;
  logic             valid;
  logic             ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);
endinterface

// File: rtl/uart_rx_packet_ctrl_fifo.sv
// Commit/rollback FIFO. Writes land beyond the commit pointer and stay invisible
// to the reader until committed; a rollback discards them by pulling the write
// pointer back to the commit pointer. The read pointer is never moved by either.
//   clock, resetn      : clock, async active-low reset
//   push, push_data    : write one entry at the write pointer
//   commit             : publish everything written so far
//   rollback           : discard everything written since the last commit
//   pop                : consume the head entry (ignored when nothing committed)
//   head               : entry at the read pointer
//   free               : DEPTH minus entries held (committed or not)
//   committed_nonempty : at least one committed entry is readable
module uart_rx_packet_ctrl_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     committed_nonempty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] cm_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers carry one extra wrap bit, so equal pointers mean empty and
  // pointers differing only in the MSB mean full.
  assign committed_nonempty = (cm_ptr != rd_ptr);
  assign free               = PTR_W'(DEPTH) - (wr_ptr - rd_ptr);
  assign head               = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  // The controller never pushes in the same cycle it commits or rolls back,
  // so commit simply captures the current write pointer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= cm_ptr;
      end else if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (commit) begin
        cm_ptr <= wr_ptr;
      end
      if (pop && committed_nonempty) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Packet sequencer behind uart_rx. Frames SYNC, LEN, LEN payload words, CHK;
// payload is held in a commit/rollback FIFO and only released downstream once
// the checksum (LEN plus payload, modulo 2^WIDTH) matches.
//   clock, resetn   : clock, async active-low reset
//   rx_data         : uart_rx word, valid while rx_ready=1
//   rx_ready        : one-cycle pulse per received word
//   rx_can_receive  : lets uart_rx accept its next start bit
//   out             : downstream payload stream (master side)
//   pkt_ok          : one-cycle pulse, packet committed
//   pkt_err         : one-cycle pulse, packet dropped
//   err_code        : cause of the last drop, held until the next drop
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_HUNT    | waiting for SYNC_WORD with room for a full packet
// S_LEN     | next word is the payload length
// S_PAYLOAD | storing payload words, accumulating checksum
// S_CHECK   | next word is the checksum; commit or roll back
module uart_rx_packet_ctrl
  import uart_rx_packet_ctrl_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               MAX_LEN       = 16,
  parameter int               DEPTH         = 32,
  parameter logic [WIDTH-1:0] SYNC_WORD     = WIDTH'(SYNC_WORD_DEFAULT),
  parameter int               TIMEOUT_TICKS = 104160
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rx_ready,
  output logic                 rx_can_receive,
  uart_rx_packet_ctrl_if.master out,
  output logic                 pkt_ok,
  output logic                 pkt_err,
  output logic [1:0]           err_code
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int REM_W = $clog2(MAX_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

  state_t           state;
  logic [REM_W-1:0] remaining;
  logic [WIDTH-1:0] sum;
  logic [TMO_W-1:0] tmo_cnt;

  logic             push;
  logic             commit;
  logic             rollback;
  logic             timeout;
  logic             chk_match;
  logic             len_ok;
  logic [PTR_W-1:0] free;
  logic             committed_nonempty;
  logic [WIDTH:0]   head;

  // A word arriving on the terminal cycle beats the timeout.
  assign timeout   = (state != S_HUNT) && !rx_ready &&
                     (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));
  assign chk_match = (rx_data == sum);
  assign len_ok    = (rx_data != '0) && (rx_data <= WIDTH'(MAX_LEN));

  assign push     = rx_ready && (state == S_PAYLOAD);
  assign commit   = rx_ready && (state == S_CHECK) && chk_match;
  assign rollback = timeout || (rx_ready && (state == S_CHECK) && !chk_match);

  // Two words of slack in HUNT cover a SYNC already in flight when the
  // gate closes; HUNT admission itself only needs room for MAX_LEN words.
  assign rx_can_receive = (state != S_HUNT) || (free >= PTR_W'(MAX_LEN + 2));

  assign out.valid = committed_nonempty;
  assign out.last  = head[WIDTH];
  assign out.data  = head[WIDTH-1:0];

  uart_rx_packet_ctrl_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock              (clock),
    .resetn             (resetn),
    .push               (push),
    .push_data          ({(remaining == REM_W'(1)), rx_data}),
    .commit             (commit),
    .rollback           (rollback),
    .pop                (out.ready),
    .head               (head),
    .free               (free),
    .committed_nonempty (committed_nonempty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_HUNT;
      remaining <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;

      if (rx_ready || (state == S_HUNT)) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (timeout) begin
        state    <= S_HUNT;
        pkt_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (rx_ready) begin
        case (state)
          S_HUNT: begin
            if ((rx_data == SYNC_WORD) && (free >= PTR_W'(MAX_LEN))) begin
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (len_ok) begin
              remaining <= REM_W'(rx_data);
              sum       <= rx_data;
              state     <= S_PAYLOAD;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
              state    <= S_HUNT;
            end
          end
          S_PAYLOAD: begin
            sum       <= sum + rx_data;
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (chk_match) begin
              pkt_ok <= 1'b1;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_CHK;
            end
            state <= S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
module tb_uart_rx_packet_ctrl;
  localparam int W       = 8;
  localparam int MAX_LEN = 16;
  localparam int DEPTH   = 32;
  localparam int T       = 64;

  logic         clock  = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] rx_data = '0;
  logic         rx_ready = 1'b0;
  logic         rx_can_receive;
  logic         pkt_ok;
  logic         pkt_err;
  logic [1:0]   err_code;

  uart_rx_packet_ctrl_if #(.WIDTH(W)) out_bus ();

  uart_rx_packet_ctrl #(
    .WIDTH         (W),
    .MAX_LEN       (MAX_LEN),
    .DEPTH         (DEPTH),
    .SYNC_WORD     (8'hA5),
    .TIMEOUT_TICKS (T)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_can_receive (rx_can_receive),
    .out            (out_bus),
    .pkt_ok         (pkt_ok),
    .pkt_err        (pkt_err),
    .err_code       (err_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // sink behaviour: 0 stalled, 1 always ready, 2 random
  int ready_mode = 0;
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_bus.ready = 1'b0;
      1:       out_bus.ready = 1'b1;
      default: out_bus.ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct {
    bit       is_err;
    logic [1:0] code;
    int       at;
  } ev_t;

  ev_t        ev_q[$];
  logic [8:0] word_q[$];
  logic [1:0] exp_err = 2'd0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [8:0] mon_w;
  ev_t        mon_e;
  always @(negedge clock) begin
    if (resetn) begin
      if (out_bus.valid && out_bus.ready) begin
        if (word_q.size() == 0) begin
          check(1'b0, "out_word", $sformatf("unexpected word got=%02h last=%0d", out_bus.data, out_bus.last));
        end else begin
          mon_w = word_q.pop_front();
          check({out_bus.last, out_bus.data} == mon_w, "out_word",
                $sformatf("got data=%02h last=%0d exp data=%02h last=%0d",
                          out_bus.data, out_bus.last, mon_w[7:0], mon_w[8]));
        end
      end
      if (pkt_ok || pkt_err) begin
        if (ev_q.size() == 0) begin
          check(1'b0, "pkt_event", $sformatf("unexpected pulse ok=%0d err=%0d code=%0d cyc=%0d",
                                             pkt_ok, pkt_err, err_code, cyc));
        end else begin
          mon_e = ev_q.pop_front();
          if (mon_e.is_err) exp_err = mon_e.code;
          check((pkt_err == mon_e.is_err) && (pkt_ok == !mon_e.is_err) &&
                (err_code == exp_err) && (cyc == mon_e.at), "pkt_event",
                $sformatf("got ok=%0d err=%0d code=%0d cyc=%0d exp ok=%0d err=%0d code=%0d cyc=%0d",
                          pkt_ok, pkt_err, err_code, cyc, !mon_e.is_err, mon_e.is_err, exp_err, mon_e.at));
        end
      end
    end
  end

  // ---------------- driver + reference model ----------------
  int         last_drv = 0;
  logic [7:0] pbuf [40];
  int         plen = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] w);
    rx_data  = w;
    rx_ready = 1'b1;
    last_drv = cyc;
    @(posedge clock);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic push_ev(input bit is_err, input logic [1:0] code, input int at);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    e.at     = at;
    ev_q.push_back(e);
  endtask

  task automatic load(input logic [47:0] bytes, input int n);
    for (int i = 0; i < n; i++) pbuf[i] = bytes[8*(n-1-i) +: 8];
    plen = n;
  endtask

  task automatic build(input int len, input logic [7:0] first, input bit corrupt);
    logic [7:0] s;
    pbuf[0] = 8'hA5;
    pbuf[1] = 8'(len);
    s = 8'(len);
    for (int i = 0; i < len; i++) begin
      pbuf[2+i] = first + 8'(i * 7);
      s = s + pbuf[2+i];
    end
    pbuf[2+len] = corrupt ? (s ^ 8'(1 + $urandom_range(0, 254))) : s;
    plen = len + 3;
  endtask

  // Sends pbuf[0..plen-1] (SYNC first, assumed admitted) and predicts the outcome
  // from the framing rules: LEN range, checksum of LEN+payload, inter-word gap.
  task automatic send_packet(input int gap_idx, input int gap_len, input bit rand_gaps);
    int         len;
    int         n;
    logic [7:0] s;
    len = 0;
    s   = 8'h00;
    drive(pbuf[0]);
    for (int i = 1; i < plen; i++) begin
      n = (i == gap_idx) ? gap_len : (rand_gaps ? int'($urandom_range(0, 3)) : 0);
      if (n + 1 > T) begin
        idle(T);
        push_ev(1'b1, 2'd3, last_drv + T + 1);
        idle(n - T);
        return;
      end
      idle(n);
      drive(pbuf[i]);
      if (i == 1) begin
        len = int'(pbuf[1]);
        if (len < 1 || len > MAX_LEN) begin
          push_ev(1'b1, 2'd1, last_drv + 1);
          return;
        end
        s = pbuf[1];
      end else if (i <= 1 + len) begin
        s = s + pbuf[i];
      end else begin
        if (pbuf[i] == s) begin
          for (int k = 0; k < len; k++) word_q.push_back({(k == len - 1), pbuf[2+k]});
          push_ev(1'b0, 2'd0, last_drv + 1);
        end else begin
          push_ev(1'b1, 2'd2, last_drv + 1);
        end
        return;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((word_q.size() != 0 || ev_q.size() != 0) && n < 3000) begin
      idle(1);
      n++;
    end
    idle(2);
    check(word_q.size() == 0 && ev_q.size() == 0, name,
          $sformatf("pending words=%0d events=%0d after %0d cycles", word_q.size(), ev_q.size(), n));
  endtask

  task automatic check_idle_outputs(input string name);
    check(out_bus.valid == 1'b0, {name, "_valid"}, $sformatf("got=%0d exp=0", out_bus.valid));
    check(pkt_ok == 1'b0 && pkt_err == 1'b0, {name, "_pulses"}, $sformatf("got ok=%0d err=%0d exp 0 0", pkt_ok, pkt_err));
    check(err_code == 2'd0, {name, "_err_code"}, $sformatf("got=%0d exp=0", err_code));
    check(rx_can_receive == 1'b1, {name, "_can_receive"}, $sformatf("got=%0d exp=1", rx_can_receive));
  endtask

  initial begin
    int n;
    logic [7:0] j;

    // reset state
    resetn = 1'b0;
    idle(3);
    check_idle_outputs("reset");
    resetn = 1'b1;
    idle(2);

    // basic good packet
    ready_mode = 1;
    load(48'hA5_03_11_22_33_69, 6);
    send_packet(-1, 0, 1'b0);
    drain("drain_basic");
    check(err_code == 2'd0, "err_code_after_ok", $sformatf("got=%0d exp=0", err_code));

    // bad checksum, nothing becomes visible, then a good packet
    load(48'h00_A5_02_10_20_00, 5);
    send_packet(-1, 0, 1'b0);
    drain("drain_badchk");
    check(out_bus.valid == 1'b0, "valid_after_badchk", $sformatf("got=%0d exp=0", out_bus.valid));
    load(48'h0000_A5_01_7F_80, 4);
    send_packet(-1, 0, 1'b0);
    drain("drain_after_badchk");

    // LEN out of range at both ends
    load(48'h0000_0000_A5_00, 2);
    send_packet(-1, 0, 1'b0);
    load(48'h0000_0000_A5_11, 2);
    send_packet(-1, 0, 1'b0);
    drain("drain_badlen");
    build(MAX_LEN, 8'h40, 1'b0);
    send_packet(-1, 0, 1'b0);
    drain("drain_maxlen");

    // timeout one cycle past the limit, then a word exactly on the limit
    load(48'h00_A5_02_10_20_32, 5);
    send_packet(3, T, 1'b0);
    drain("drain_timeout");
    load(48'h00_A5_02_10_20_32, 5);
    send_packet(3, T - 1, 1'b0);
    drain("drain_timeout_edge");

    // backpressure: two full packets with the sink stalled
    ready_mode = 0;
    idle(2);
    build(MAX_LEN, 8'h01, 1'b0);
    send_packet(-1, 0, 1'b0);
    idle(2);
    check(rx_can_receive == 1'b0, "can_receive_half_full", $sformatf("got=%0d exp=0", rx_can_receive));
    build(MAX_LEN, 8'h80, 1'b0);
    send_packet(-1, 0, 1'b0);
    idle(2);
    check(rx_can_receive == 1'b0, "can_receive_full", $sformatf("got=%0d exp=0", rx_can_receive));
    ready_mode = 1;
    drain("drain_backpressure");
    check(rx_can_receive == 1'b1, "can_receive_drained", $sformatf("got=%0d exp=1", rx_can_receive));

    // reset in the middle of a payload with committed data still queued
    ready_mode = 0;
    idle(2);
    load(48'hA5_03_11_22_33_69, 6);
    send_packet(-1, 0, 1'b0);
    idle(3);
    drive(8'hA5);
    drive(8'h04);
    drive(8'h01);
    drive(8'h02);
    resetn = 1'b0;
    word_q.delete();
    ev_q.delete();
    exp_err = 2'd0;
    idle(2);
    check_idle_outputs("midreset");
    resetn = 1'b1;
    ready_mode = 1;
    idle(3);
    check(out_bus.valid == 1'b0, "valid_after_midreset", $sformatf("got=%0d exp=0", out_bus.valid));
    load(48'h0000_A5_01_7F_80, 4);
    send_packet(-1, 0, 1'b0);
    drain("drain_after_midreset");

    // randomized traffic against the model, random sink stalls
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        drive(j);
        idle($urandom_range(0, 2));
      end
      n = 0;
      while (!rx_can_receive && n < 3000) begin
        idle(1);
        n++;
      end
      check(rx_can_receive == 1'b1, "admit_wait", $sformatf("got=%0d exp=1 after %0d cycles", rx_can_receive, n));
      if ($urandom_range(0, 7) == 0) begin
        pbuf[0] = 8'hA5;
        pbuf[1] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(MAX_LEN + 1 + $urandom_range(0, 200));
        plen = 2;
        send_packet(-1, 0, 1'b1);
      end else begin
        build($urandom_range(1, MAX_LEN), 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) == 0) send_packet($urandom_range(1, plen - 1), T + $urandom_range(0, 3), 1'b1);
        else send_packet(-1, 0, 1'b1);
      end
    end
    ready_mode = 1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
